// File: rtl/pr_write_packer.sv
// Packs WIDTH-bit elements into FULL_WIDTH-bit lines (addr, slot mask, data) and queues them for the memory write port.
// Latency: a closed line is visible at the queue head one cycle after the closing write/flush (FWFT queue).
// Backpressure: full stalls both element writes and flush; rdreq pops the head, ignored while empty.
module pr_write_packer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int LOG_DEPTH  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          wrreq,
    input  logic [WIDTH-1:0]                              wdata,
    input  logic [ADDR_WIDTH-1:0]                         waddr,
    input  logic                                          flush,
    output logic                                          full,
    input  logic                                          rdreq,
    output logic                                          empty,
    output logic [FULL_WIDTH-1:0]                         rdata,
    output logic [FULL_WIDTH/WIDTH-1:0]                   rmask,
    output logic [ADDR_WIDTH-$clog2(FULL_WIDTH/WIDTH)-1:0] raddr,
    output logic [7:0]                                    base,
    output logic [7:0]                                    bounds
);
    localparam int MAX_ELEMS = FULL_WIDTH / WIDTH;
    localparam int SLOT_BITS = $clog2(MAX_ELEMS);
    localparam int LINE_AW   = ADDR_WIDTH - SLOT_BITS;
    localparam int DEPTH     = 2 ** LOG_DEPTH;

    typedef enum logic {IDLE, OPEN} state_t;

    typedef struct packed {
        logic [LINE_AW-1:0]    addr;
        logic [MAX_ELEMS-1:0]  mask;
        logic [FULL_WIDTH-1:0] data;
    } line_t;

    state_t                state, state_nxt;
    logic [LINE_AW-1:0]    cur_addr, cur_addr_nxt;
    logic [MAX_ELEMS-1:0]  cur_mask, cur_mask_nxt;
    logic [FULL_WIDTH-1:0] cur_data, cur_data_nxt;

    logic                  accept, diff_line, mrg_open, close;
    logic [LINE_AW-1:0]    in_line, mrg_addr;
    logic [SLOT_BITS-1:0]  in_slot;
    logic [MAX_ELEMS-1:0]  mrg_mask;
    logic [FULL_WIDTH-1:0] mrg_data;

    logic                  push_vld, pop;
    line_t                 push_dat, head_dat;
    line_t                 mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]    count;

    assign in_line   = waddr[ADDR_WIDTH-1:SLOT_BITS];
    assign in_slot   = waddr[SLOT_BITS-1:0];
    assign accept    = wrreq && !full;
    assign diff_line = accept && (state == OPEN) && (in_line != cur_addr);

    // Line as it stands after this cycle's element: the open line, or a fresh one on IDLE/line change.
    always_comb begin
        if (state == OPEN && !diff_line) begin
            mrg_addr = cur_addr;
            mrg_mask = cur_mask;
            mrg_data = cur_data;
        end else begin
            mrg_addr = in_line;
            mrg_mask = '0;
            mrg_data = '0;
        end
        for (int k = 0; k < MAX_ELEMS; k++) begin
            if (accept && in_slot == SLOT_BITS'(k)) begin
                mrg_mask[k] = 1'b1;
                mrg_data[FULL_WIDTH-1-k*WIDTH -: WIDTH] = wdata;
            end
        end
        mrg_open = (state == OPEN) || accept;
        close    = mrg_open && !diff_line &&
                   ((&mrg_mask) || (flush && !full && state == OPEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            cur_mask <= '0;
            cur_data <= '0;
        end else begin
            state    <= state_nxt;
            cur_addr <= cur_addr_nxt;
            cur_mask <= cur_mask_nxt;
            cur_data <= cur_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = IDLE;
        cur_addr_nxt = '0;
        cur_mask_nxt = '0;
        cur_data_nxt = '0;
        if (mrg_open && !close) begin
            state_nxt    = OPEN;
            cur_addr_nxt = mrg_addr;
            cur_mask_nxt = mrg_mask;
            cur_data_nxt = mrg_data;
        end
    end

    // A line change pushes the old line; completion/flush pushes the merged one. Never both.
    always_comb begin
        push_vld = diff_line || close;
        if (diff_line) begin
            push_dat.addr = cur_addr;
            push_dat.mask = cur_mask;
            push_dat.data = cur_data;
        end else begin
            push_dat.addr = mrg_addr;
            push_dat.mask = mrg_mask;
            push_dat.data = mrg_data;
        end
    end

    assign full  = count[LOG_DEPTH];
    assign empty = (count == '0);
    assign pop   = rdreq && !empty;

    always_ff @(posedge clk) begin
        if (push_vld && !full) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld && !full) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            if (pop)               rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            case ({push_vld && !full, pop})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign rdata    = head_dat.data;
    assign rmask    = head_dat.mask;
    assign raddr    = head_dat.addr;

    always_comb begin
        base   = '0;
        bounds = '0;
        for (int k = MAX_ELEMS - 1; k >= 0; k--) begin
            if (head_dat.mask[k]) base = 8'(k);
        end
        for (int k = 0; k < MAX_ELEMS; k++) begin
            if (head_dat.mask[k]) bounds = 8'(k + 1);
        end
    end
endmodule

// File: tb/tb_pr_write_packer.sv
// Bench for pr_write_packer: table-driven lines plus hand-written multi-cycle sequences, scoreboard-checked.
module tb_pr_write_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic         wrreq;
    logic [63:0]  wdata;
    logic [31:0]  waddr;
    logic         flush;
    logic         full;
    logic         rdreq;
    logic         empty;
    logic [511:0] rdata;
    logic [7:0]   rmask;
    logic [28:0]  raddr;
    logic [7:0]   base;
    logic [7:0]   bounds;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [28:0]  addr;
        logic [7:0]   mask;
        logic [7:0]   base;
        logic [7:0]   bounds;
        logic [511:0] dat;
    } exp_t;

    typedef struct {
        logic [31:0] a0;
        int          n;
        logic [63:0] d0;
        bit          fl;
        logic [28:0] raddr;
        logic [7:0]  mask;
        logic [7:0]  base;
        logic [7:0]  bounds;
    } vec_t;

    exp_t sb[$];

    pr_write_packer dut (
        .clk(clk), .rst(rst), .wrreq(wrreq), .wdata(wdata), .waddr(waddr),
        .flush(flush), .full(full), .rdreq(rdreq), .empty(empty), .rdata(rdata),
        .rmask(rmask), .raddr(raddr), .base(base), .bounds(bounds)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] put_slot(input logic [511:0] d, input int slot, input logic [63:0] v);
        logic [511:0] r;
        r = d;
        r[511-slot*64 -: 64] = v;
        return r;
    endfunction

    function automatic exp_t mk(input logic [28:0] a, input logic [7:0] m, input logic [511:0] d);
        exp_t e;
        e.addr = a; e.mask = m; e.dat = d; e.base = 8'd0; e.bounds = 8'd0;
        for (int k = 0; k < 8; k++) if (m[k]) begin e.bounds = 8'(k + 1); end
        for (int k = 7; k >= 0; k--) if (m[k]) begin e.base = 8'(k); end
        return e;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        wrreq = 1'b1; waddr = a; wdata = d;
        tick();
        wrreq = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic cmp_head();
        exp_t e;
        e = sb.pop_front();
        check("raddr", raddr, e.addr);
        check("rmask", rmask, e.mask);
        check("base", base, e.base);
        check("bounds", bounds, e.bounds);
        check("rdata", rdata, e.dat);
    endtask

    task automatic drain(input int budget);
        int waited = 0;
        while (sb.size() > 0) begin
            if (!empty) begin
                cmp_head();
                rdreq = 1'b1;
                tick();
                rdreq = 1'b0;
                waited = 0;
            end else if (waited >= budget) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: %0d lines still expected, queue empty", sb.size());
                sb.delete();
            end else begin
                tick();
                waited++;
            end
        end
        check("empty_after_drain", empty, 1'b1);
    endtask

    initial begin
        vec_t         vt[5];
        logic [511:0] d;
        logic [7:0]   m;

        vt[0] = '{a0: 32'd0,  n: 8, d0: 64'h10,  fl: 1'b0, raddr: 29'd0, mask: 8'hFF, base: 8'd0, bounds: 8'd8};
        vt[1] = '{a0: 32'd18, n: 2, d0: 64'h100, fl: 1'b1, raddr: 29'd2, mask: 8'h0C, base: 8'd2, bounds: 8'd4};
        vt[2] = '{a0: 32'd41, n: 3, d0: 64'h200, fl: 1'b1, raddr: 29'd5, mask: 8'h0E, base: 8'd1, bounds: 8'd4};
        vt[3] = '{a0: 32'd79, n: 1, d0: 64'h300, fl: 1'b1, raddr: 29'd9, mask: 8'h80, base: 8'd7, bounds: 8'd8};
        vt[4] = '{a0: 32'd64, n: 1, d0: 64'h400, fl: 1'b1, raddr: 29'd8, mask: 8'h01, base: 8'd0, bounds: 8'd1};

        rst = 1'b1; wrreq = 1'b0; wdata = '0; waddr = '0; flush = 1'b0; rdreq = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);

        // Table-driven single-line cases
        foreach (vt[i]) begin
            exp_t e;
            d = '0;
            for (int j = 0; j < vt[i].n; j++)
                d = put_slot(d, int'((vt[i].a0 + 32'(j)) % 8), vt[i].d0 + 64'(j));
            e = '{addr: vt[i].raddr, mask: vt[i].mask, base: vt[i].base, bounds: vt[i].bounds, dat: d};
            sb.push_back(e);
            for (int j = 0; j < vt[i].n; j++) wr(vt[i].a0 + 32'(j), vt[i].d0 + 64'(j));
            if (vt[i].fl) do_flush();
            drain(4);
        end

        // Line change without flush pushes the old line; new line stays open
        sb.push_back(mk(29'd0, 8'h08, put_slot('0, 3, 64'h33)));
        wr(32'd3, 64'h33);
        wr(32'd9, 64'h99);
        check("diff_line_visible", empty, 1'b0);
        drain(4);
        sb.push_back(mk(29'd1, 8'h02, put_slot('0, 1, 64'h99)));
        do_flush();
        drain(4);

        // Rewrite of a set slot: last write wins
        sb.push_back(mk(29'd0, 8'h20, put_slot('0, 5, 64'hBB)));
        wr(32'd5, 64'hAA);
        wr(32'd5, 64'hBB);
        do_flush();
        drain(4);

        // Fill the queue to full, stall, pop once, resume
        for (int l = 0; l < 16; l++) begin
            d = '0;
            for (int s = 0; s < 8; s++) d = put_slot(d, s, 64'h1000 + 64'(l * 16 + s));
            sb.push_back(mk(29'(100 + l), 8'hFF, d));
            if (l == 15) check("not_full_at_15", full, 1'b0);
            for (int s = 0; s < 8; s++) wr(32'((100 + l) * 8 + s), 64'h1000 + 64'(l * 16 + s));
        end
        check("full_after_16", full, 1'b1);
        wrreq = 1'b1; waddr = 32'(200 * 8 + 1); wdata = 64'hBAD;
        tick();
        tick();
        check("full_held", full, 1'b1);
        d = '0;
        for (int s = 0; s < 8; s++) d = put_slot(d, s, 64'h5000 + 64'(s));
        cmp_head();
        sb.push_back(mk(29'd116, 8'hFF, d));
        waddr = 32'(116 * 8); wdata = 64'h5000; rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        check("full_after_pop", full, 1'b0);
        tick();
        wrreq = 1'b0;
        for (int s = 1; s < 8; s++) wr(32'(116 * 8 + s), 64'h5000 + 64'(s));
        check("refull_after_resume", full, 1'b1);
        drain(4);

        // Reset mid-operation discards queued and open lines
        for (int l = 0; l < 3; l++)
            for (int s = 0; s < 8; s++) wr(32'((300 + l) * 8 + s), 64'(s));
        wr(32'(303 * 8 + 2), 64'h77);
        check("pre_reset_nonempty", empty, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_empty", empty, 1'b1);
        check("mid_reset_full", full, 1'b0);
        do_flush();
        tick();
        check("flush_after_reset", empty, 1'b1);

        m = 8'hFF;
        d = '0;
        for (int s = 0; s < 8; s++) d = put_slot(d, s, 64'hC0 + 64'(s));
        sb.push_back(mk(29'd7, m, d));
        for (int s = 0; s < 8; s++) wr(32'(7 * 8 + s), 64'hC0 + 64'(s));
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
